// File: rtl/store_narrow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow_pkg
// Description : Shared definitions for the store-path narrowing unit.
//               Holds the access-size encodings, the controller state enum,
//               and the byte_count() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package store_narrow_pkg;

  // Access-size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of bytes written for a given access size.
  // The reserved encoding yields zero; it never reaches the WRITE state.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage : store_narrow_pkg
`default_nettype wire

// File: rtl/store_narrow_byte_lane_sel.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_sel
// Description : Combinational 4:1 byte mux. Picks little-endian lane cnt of
//               the 32-bit register value: lane k = data[8k+7:8k].
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_sel #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            cnt,
  output logic [7:0]            lane
);

  // Select the byte lane addressed by the byte counter.
  always_comb begin
    lane = 8'h00;
    case (cnt)
      2'd0:    lane = data[7:0];
      2'd1:    lane = data[15:8];
      2'd2:    lane = data[23:16];
      2'd3:    lane = data[31:24];
      default: lane = 8'h00;
    endcase
  end

endmodule : byte_lane_sel
`default_nettype wire

// File: rtl/store_narrow.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow
// Description : Store-path narrowing unit. Accepts one 32-bit store request
//               (value, byte address, size) and writes the selected byte,
//               halfword or word into a byte-wide data memory, one byte per
//               mem_ready handshake, little-endian, with address wrap.
//               req_ready low stalls the pipeline while a store is in flight.
//               Optional build macro STORE_NARROW_ALIGN_CHECK_EN: when
//               defined, misaligned halfword/word stores are rejected with
//               err=1 and no bytes written; otherwise they are written byte
//               by byte at base+k.
// Revision    : 1.0 - initial release
// ============================================================================
module store_narrow
  import store_narrow_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ready,
  output logic                  done,
  output logic                  err
);

  // Control state and latched request.
  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            size_q, size_d;

  // Registered outputs.
  logic                  req_ready_q, req_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Helper nets.
  logic                  misaligned;
  logic [2:0]            n_bytes;
  logic                  last_byte;
  logic [7:0]            lane_next;

`ifdef STORE_NARROW_ALIGN_CHECK_EN
  // Flag halfword stores on odd addresses and word stores off a 4-byte boundary.
  always_comb begin
    misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end
`else
  // Without the alignment check every non-reserved size is written as-is.
  assign misaligned = 1'b0;
`endif

  assign n_bytes   = byte_count(size_q);
  assign last_byte = ({1'b0, cnt_q} == (n_bytes - 3'd1));

  // Next-state logic: latch the request on accept, step the byte counter on
  // each memory handshake, and finish through DONE for exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    data_d  = data_q;
    size_d  = size_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          base_d = req_addr;
          data_d = req_data;
          size_d = req_size;
          cnt_d  = 2'd0;
          if ((req_size == SZ_RSVD) || misaligned) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (mem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (last_byte) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lane mux driven by the next-cycle data and counter so that the output
  // byte is registered together with the address it belongs to.
  byte_lane_sel #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_sel (
    .data (data_d),
    .cnt  (cnt_d),
    .lane (lane_next)
  );

  // Output decode from the next state; everything leaves through a flop, so
  // req_* never reaches mem_* within the same cycle.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    mem_we_d    = (state_d == ST_WRITE);
    done_d      = (state_d == ST_DONE);
    mem_addr_d  = '0;
    mem_wdata_d = 8'h00;
    if (mem_we_d) begin
      mem_addr_d  = base_d + ADDR_WIDTH'(cnt_d);
      mem_wdata_d = lane_next;
    end
  end

  // State, latched request and output registers; reset drops any store in
  // flight without issuing done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      base_q      <= '0;
      data_q      <= '0;
      size_q      <= SZ_BYTE;
      req_ready_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      data_q      <= data_d;
      size_q      <= size_d;
      req_ready_q <= req_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule : store_narrow
`default_nettype wire

// File: tb/tb_store_narrow.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_narrow
// Description : Self-checking bench for store_narrow. Table of store requests
//               with expected byte count, error and latency; expected memory
//               writes are queued when a request is driven and compared as
//               the DUT writes them. Hand sequences cover reset mid-store.
//               Honors STORE_NARROW_ALIGN_CHECK_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_narrow;

  localparam int AW = 10;

`ifdef STORE_NARROW_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_data = '0;
  logic [1:0]    req_size = 2'b00;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ready = 1'b0;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  store_narrow #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [1:0]    size;
    int            stall;
    int            exp_n;
    bit            exp_err;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t  wq[$];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tab[11];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Write scoreboard: every mem_we cycle must match the head of the queue
  // (also while stalled, which proves the outputs hold); pop on handshake.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        check("wr_addr", 32'(mem_addr), 32'(wq[0].a));
        check("wr_data", 32'(mem_wdata), 32'(wq[0].d));
        if (mem_ready) void'(wq.pop_front());
      end
    end
  end

  task automatic check_idle_outputs(string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
  endtask

  // Drive one request from an idle cycle (called just after a rising edge)
  // and follow it to its done pulse.
  task automatic run_vec(input vec_t v, input int idx);
    int c;
    bit seen;
    int exp_lat;
    logic [31:0] d;
    d = v.data;
    exp_lat = v.exp_err ? 1 : (v.exp_n + v.stall + 1);
    if (!v.exp_err) begin
      for (int k = 0; k < v.exp_n; k++) begin
        wq.push_back('{a: v.addr + AW'(k), d: d[8*k +: 8]});
      end
    end
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    req_valid = 1'b1;
    mem_ready = (v.stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = 1;
    mem_ready = (c > v.stall);
    seen = 1'b0;
    while (!seen && c <= 60) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        check($sformatf("v%0d_latency", idx), 32'(c), 32'(exp_lat));
        check($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d_busy_in_done", idx), 32'(req_ready), 32'd0);
      end else begin
        @(posedge clk); #1;
        c++;
        mem_ready = (c > v.stall);
      end
    end
    if (!seen) begin
      check($sformatf("v%0d_done_timeout", idx), 32'(done), 32'd1);
    end else begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
      check($sformatf("v%0d_ready_after", idx), 32'(req_ready), 32'd1);
    end
    check($sformatf("v%0d_writes_left", idx), 32'(wq.size()), 32'd0);
    wq.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t post;

    tab[0]  = '{addr: 10'h013, data: 32'hAABBCCDD, size: 2'b00, stall: 0, exp_n: 1, exp_err: 1'b0};
    tab[1]  = '{addr: 10'h020, data: 32'h11223344, size: 2'b10, stall: 0, exp_n: 4, exp_err: 1'b0};
    tab[2]  = '{addr: 10'h0A2, data: 32'h0000BEEF, size: 2'b01, stall: 3, exp_n: 2, exp_err: 1'b0};
    tab[3]  = '{addr: 10'h001, data: 32'h0000BEEF, size: 2'b01, stall: 0, exp_n: 2, exp_err: ALIGN_CHK};
    tab[4]  = '{addr: 10'h040, data: 32'h12345678, size: 2'b11, stall: 0, exp_n: 0, exp_err: 1'b1};
    tab[5]  = '{addr: 10'h102, data: 32'hDEADBEEF, size: 2'b10, stall: 0, exp_n: 4, exp_err: ALIGN_CHK};
    tab[6]  = '{addr: 10'h3FF, data: 32'h0000C0DE, size: 2'b01, stall: 0, exp_n: 2, exp_err: ALIGN_CHK};
    tab[7]  = '{addr: 10'h3FF, data: 32'h123456A5, size: 2'b00, stall: 0, exp_n: 1, exp_err: 1'b0};
    tab[8]  = '{addr: 10'h3FC, data: 32'h89ABCDEF, size: 2'b10, stall: 1, exp_n: 4, exp_err: 1'b0};
    tab[9]  = '{addr: 10'h0A2, data: 32'h12345678, size: 2'b01, stall: 0, exp_n: 2, exp_err: 1'b0};
    tab[10] = '{addr: 10'h3FD, data: 32'h0BADF00D, size: 2'b11, stall: 2, exp_n: 0, exp_err: 1'b1};

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_vec(tab[i], i);
    end

    // Word store at 0x3FC, reset after the second byte has been written.
    wq.push_back('{a: 10'h3FC, d: 8'h0D});
    wq.push_back('{a: 10'h3FD, d: 8'hF0});
    req_addr  = 10'h3FC;
    req_data  = 32'hCAFEF00D;
    req_size  = 2'b10;
    req_valid = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_bytes_written", 32'(wq.size()), 32'd0);
    check_idle_outputs("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_mid_reset");
    check("rst_no_done_after", 32'(done), 32'd0);
    @(posedge clk); #1;

    // Next request after the reset is accepted normally.
    post = '{addr: 10'h050, data: 32'h0000A1B2, size: 2'b01, stall: 0, exp_n: 2, exp_err: 1'b0};
    run_vec(post, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_store_narrow
`default_nettype wire

// File: doc/store_narrow.md
# store_narrow

Store-path narrowing unit for the pipeline's data memory: accepts one 32-bit store request (register value, byte address, access size) and writes only the selected byte, halfword or word into a byte-wide data memory, one byte per handshake. It is the write-side counterpart of the load-side extension logic: that logic widens memory data to register width, and this block narrows register data to memory width. It sits between the MEM stage and the data memory. Its busy indication, req_ready low, stalls the pipeline.

## Interface
- DATA_WIDTH, 32, register data width; fixed at 32 (four byte lanes)
- ADDR_WIDTH, 10, byte-address width of the data memory
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  block idle, can accept a request
- req_addr  in  ADDR_WIDTH  byte address of the store
- req_data  in  DATA_WIDTH  register value (rt)
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- mem_we  out  1  byte write strobe
- mem_addr  out  ADDR_WIDTH  byte address being written
- mem_wdata  out  8  byte being written
- mem_ready  in  1  memory accepts the current byte this cycle
- done  out  1  one-cycle pulse, request finished
- err  out  1  valid only with done; 1 = request rejected, no bytes written

## Operation
- States:
  - IDLE: req_ready=1.
  - WRITE: issues bytes.
  - DONE: done=1 for one cycle.
- Accept: req_valid && req_ready in IDLE latches addr, data and size, and clears the byte counter cnt.
- Byte count N:
  - byte 1, half 2, word 4.
  - size 11 is rejected: go to DONE with err=1.
- Alignment, with the alignment check compiled in:
  - a half with addr[0]=1 is rejected (DONE, err=1);
  - a word with addr[1:0]≠0 is rejected (DONE, err=1).
- Little-endian lane mapping:
  - byte k goes to address base+k, modulo 2^ADDR_WIDTH;
  - its value is data[8k+7:8k];
  - byte stores take data[7:0] regardless of addr.
- WRITE:
  - mem_we=1, mem_addr=base+cnt, mem_wdata=lane(cnt).
  - On mem_ready, cnt increments.
  - On mem_ready with cnt=N-1, go to DONE.
  - Without mem_ready, outputs hold stable.
- DONE: done=1, err as determined, req_ready=0; next state IDLE.
- A rejected request produces no mem_we cycle.

## Timing
- Reset values: req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0; state IDLE, cnt=0.
- Outputs are registered from the state and latched data. No combinational path from req_* to mem_*.
- With mem_ready tied high and the request accepted at cycle 0:
  - byte: write in cycle 1, done in cycle 2, req_ready in cycle 3;
  - word: writes in cycles 1–4, done in cycle 5.
- Rejected request: done=err=1 in cycle 1.
- req_valid while req_ready=0 is ignored. The requester holds the request until accepted.
- Reset asserted mid-operation: return to IDLE immediately. Bytes already written stay in memory. No done is issued.
- Address wrap: base+k wraps modulo 2^ADDR_WIDTH. No error is raised for wrap.

## Configuration
- STORE_NARROW_ALIGN_CHECK_EN defined:
  - misaligned half and word requests are rejected with err=1;
  - no bytes are written.
- STORE_NARROW_ALIGN_CHECK_EN not defined:
  - misaligned requests are accepted and written byte by byte at base+k, with wrap;
  - err is raised only for size 11.

## Structure
- Shared package store_narrow_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the state enum;
  - a byte_count(size) function.
- Sub-module byte_lane_sel: combinational 4:1 byte mux, (data, cnt) → mem_wdata source.

## Test plan
- Byte store, addr=0x013, data=0xAABBCCDD, mem_ready=1 → single write 0xDD at 0x013; done in cycle 2; err=0.
- Word store, addr=0x020, data=0x11223344, mem_ready=1 → writes 0x44@0x020, 0x33@0x021, 0x22@0x022, 0x11@0x023 in cycles 1–4; done in cycle 5.
- Half store, addr=0x0A2, data=0x0000BEEF, mem_ready low for 3 cycles on the first byte → 0xEF@0x0A2 held stable for 4 cycles, then 0xBE@0x0A3; done.
- Half at addr=0x001 with STORE_NARROW_ALIGN_CHECK_EN defined → no mem_we; done=err=1 in cycle 1. Without the macro → 0xEF@0x001, 0xBE@0x002; err=0.
- size=11 → done=err=1, no writes, in both builds.
- Word store at 0x3FC, rst_n pulsed low after the 2nd byte → outputs return to reset values; no done; the next request is accepted normally.
